// File: rtl/scan_pkg.sv
// Shared types, defaults and helpers for the multi-pattern scan controller.
package scan_pkg;

  localparam int DEF_LEN_W    = 20;
  localparam int DEF_PAT_W    = 8;
  localparam int DEF_MAX_CAP  = 4;
  localparam int DEF_DIV_LOG2 = 2;
  localparam int DEF_GAP_CYC  = 4;
  localparam int DEF_RST_CYC  = 8;

  typedef enum logic [3:0] {
    IDLE,
    SUBRST,
    LOAD,
    GAP_F,
    CAP,
    GAP_R,
    UNLOAD,
    DONE,
    ABORT
  } scan_state_t;

  // A zero burst length still means one capture pulse; longer bursts saturate.
  function automatic int clamp_cap(input int n, input int max_cap);
    if (n < 1) return 1;
    if (n > max_cap) return max_cap;
    return n;
  endfunction

endpackage

// File: rtl/scan_ctrl_multi_shift_gen.sv
// Divided shift clock for a run of len bits; shared by the load and unload phases.
module scan_shift_gen #(
  parameter int LEN_W    = 20,
  parameter int DIV_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [LEN_W-1:0] len,
  output logic             tck,
  output logic             done
);

  localparam int PH_W = DIV_LOG2 + 1;

  logic [PH_W-1:0]  ph;
  logic [LEN_W-1:0] rem;

  // Phase counter: low half then high half of each bit; parked at zero when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ph <= '0;
    else if (!run) ph <= '0;
    else           ph <= ph + PH_W'(1);
  end

  // Remaining-bit down-counter, reloaded whenever the generator is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rem <= '0;
    else if (!run) rem <= len;
    else if (&ph)  rem <= rem - LEN_W'(1);
  end

  assign tck  = ph[DIV_LOG2];
  assign done = (&ph) && (rem == LEN_W'(1));

endmodule

// File: rtl/scan_ctrl_multi.sv
// Scan/capture controller: sub-block reset, multi-pattern load/capture loop,
// final unload and lock-loss abort.
//
//   state  | meaning
//   IDLE   | waiting for start with lock present
//   SUBRST | sub_rst held for RST_CYC cycles
//   LOAD   | shifting scan_len bits in, test_se = 1
//   GAP_F  | dead time before capture, test_se = 0
//   CAP    | capture burst of cap_num pulses
//   GAP_R  | dead time after capture, test_se = 1
//   UNLOAD | final shift of scan_len bits
//   DONE   | one cycle, scan_done set
//   ABORT  | one cycle after lock loss, abort set
module scan_ctrl_multi
  import scan_pkg::*;
#(
  parameter int LEN_W    = DEF_LEN_W,
  parameter int PAT_W    = DEF_PAT_W,
  parameter int MAX_CAP  = DEF_MAX_CAP,
  parameter int DIV_LOG2 = DEF_DIV_LOG2,
  parameter int GAP_CYC  = DEF_GAP_CYC,
  parameter int RST_CYC  = DEF_RST_CYC
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           lock,
  input  logic [LEN_W-1:0]               scan_len,
  input  logic [PAT_W-1:0]               pat_num,
  input  logic [$clog2(MAX_CAP+1)-1:0]   cap_num,
  output logic                           tck,
  output logic                           test_se,
  output logic                           sub_rst,
  output logic                           busy,
  output logic                           scan_done,
  output logic                           abort,
  output logic [PAT_W-1:0]               pat_cnt
);

  localparam int CAP_W   = $clog2(MAX_CAP + 1);
  localparam int TMR_A   = (RST_CYC > GAP_CYC) ? RST_CYC : GAP_CYC;
  localparam int TMR_MAX = (TMR_A > 2 * MAX_CAP) ? TMR_A : 2 * MAX_CAP;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  scan_state_t      state, state_next;
  logic             lock_m, lock_s;
  logic [LEN_W-1:0] len_q;
  logic [PAT_W-1:0] pat_num_q;
  logic [CAP_W-1:0] cap_q;
  logic [TMR_W-1:0] tmr;
  logic             tmr_end;
  logic             accept;
  logic             shift_run, shift_tck, shift_done;
  logic             cap_tck;
  logic [PAT_W:0]   pat_inc;
  logic             more_pat;

  assign tmr_end  = (tmr == '0);
  assign pat_inc  = {1'b0, pat_cnt} + (PAT_W+1)'(1);
  assign more_pat = (pat_inc < {1'b0, pat_num_q});

  // Two-flop synchroniser for the asynchronous ADPLL lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= lock;
      lock_s <= lock_m;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; a zero shift length skips LOAD/UNLOAD entirely.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && lock_s) begin
          state_next = SUBRST;
          accept     = 1'b1;
        end
      end
      SUBRST: begin
        if (tmr_end) begin
          if (pat_num_q == '0)    state_next = DONE;
          else if (len_q == '0)   state_next = GAP_F;
          else                    state_next = LOAD;
        end
      end
      LOAD:   if (shift_done) state_next = GAP_F;
      GAP_F:  if (tmr_end)    state_next = CAP;
      CAP:    if (tmr_end)    state_next = GAP_R;
      GAP_R: begin
        if (tmr_end) begin
          if (more_pat) state_next = (len_q == '0) ? GAP_F : LOAD;
          else          state_next = (len_q == '0) ? DONE  : UNLOAD;
        end
      end
      UNLOAD: if (shift_done) state_next = DONE;
      DONE:   state_next = IDLE;
      ABORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (!lock_s && (state != IDLE) && (state != DONE) && (state != ABORT))
      state_next = ABORT;
  end

  // Phase timer for SUBRST, the gaps and the capture burst; reloaded on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr <= '0;
    end else if (state_next != state) begin
      case (state_next)
        SUBRST:       tmr <= TMR_W'(RST_CYC - 1);
        GAP_F, GAP_R: tmr <= TMR_W'(GAP_CYC - 1);
        CAP:          tmr <= TMR_W'({cap_q, 1'b0}) - TMR_W'(1);
        default:      tmr <= '0;
      endcase
    end else if (!tmr_end) begin
      tmr <= tmr - TMR_W'(1);
    end
  end

  // Run configuration, captured on the accepting cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      pat_num_q <= '0;
      cap_q     <= '0;
    end else if (accept) begin
      len_q     <= scan_len;
      pat_num_q <= pat_num;
      cap_q     <= CAP_W'(clamp_cap(int'(cap_num), MAX_CAP));
    end
  end

  // Pattern counter and sticky completion/abort flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_cnt   <= '0;
      scan_done <= 1'b0;
      abort     <= 1'b0;
    end else if (accept) begin
      pat_cnt   <= '0;
      scan_done <= 1'b0;
      abort     <= 1'b0;
    end else begin
      if (state == GAP_R && tmr_end && state_next != ABORT)
        pat_cnt <= pat_inc[PAT_W-1:0];
      if (state_next == DONE)  scan_done <= 1'b1;
      if (state_next == ABORT) abort     <= 1'b1;
    end
  end

  // Capture clock: high on the first CAP cycle, toggling at clk/2, forced low on exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cap_tck <= 1'b0;
    else     cap_tck <= (state_next == CAP) && !cap_tck;
  end

  // The shift generator only runs while staying inside a shift state, so it
  // starts at phase zero on entry and drops tck on the same edge we leave.
  assign shift_run = ((state == LOAD)      || (state == UNLOAD)) &&
                     ((state_next == LOAD) || (state_next == UNLOAD));

  scan_shift_gen #(
    .LEN_W    (LEN_W),
    .DIV_LOG2 (DIV_LOG2)
  ) u_shift (
    .clk  (clk),
    .rst  (rst),
    .run  (shift_run),
    .len  (len_q),
    .tck  (shift_tck),
    .done (shift_done)
  );

  assign tck = shift_tck | cap_tck;

  // Per-state control outputs.
  always_comb begin
    test_se = 1'b0;
    sub_rst = 1'b0;
    busy    = 1'b0;
    unique case (state)
      SUBRST:               begin sub_rst = 1'b1; busy = 1'b1; end
      LOAD, UNLOAD, GAP_R:  begin test_se = 1'b1; busy = 1'b1; end
      GAP_F, CAP:           busy = 1'b1;
      default:              ;
    endcase
  end

endmodule

// File: tb/tb_scan_ctrl_multi.sv
// Directed bench for scan_ctrl_multi at default parameters.
module tb_scan_ctrl_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        lock;
  logic [19:0] scan_len;
  logic [7:0]  pat_num;
  logic [2:0]  cap_num;
  logic        tck, test_se, sub_rst, busy, scan_done, abort;
  logic [7:0]  pat_cnt;

  int n_checks = 0;
  int n_err    = 0;

  scan_ctrl_multi dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .lock      (lock),
    .scan_len  (scan_len),
    .pat_num   (pat_num),
    .cap_num   (cap_num),
    .tck       (tck),
    .test_se   (test_se),
    .sub_rst   (sub_rst),
    .busy      (busy),
    .scan_done (scan_done),
    .abort     (abort),
    .pat_cnt   (pat_cnt)
  );

  always #5 clk = ~clk;

  // Waveform monitor, sampled on the falling edge.
  logic mon_clr = 1'b0;
  int   n_shift, n_cap, n_bad_run, n_busy, n_sub, n_done_rise, n_haz, run_len;
  logic prev_tck = 1'b0, prev_se = 1'b0, prev_done = 1'b0, run_se = 1'b0;

  always @(negedge clk) begin
    if (mon_clr) begin
      n_shift = 0; n_cap = 0; n_bad_run = 0; n_busy = 0;
      n_sub = 0; n_done_rise = 0; n_haz = 0; run_len = 0;
    end else begin
      if (tck && !prev_tck) begin
        run_se = test_se;
        if (test_se) n_shift++;
        else         n_cap++;
      end
      if (tck) run_len++;
      else begin
        if (prev_tck && run_len != (run_se ? 4 : 1)) n_bad_run++;
        run_len = 0;
      end
      if (busy) n_busy++;
      if (sub_rst) n_sub++;
      if (scan_done && !prev_done) n_done_rise++;
      if (test_se != prev_se && tck) n_haz++;
    end
    prev_tck  = tck;
    prev_se   = test_se;
    prev_done = scan_done;
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Full run with optional spurious start while busy.
  task automatic do_run(input int len, input int pat, input int cap, input bit mid_start);
    bit got;
    scan_len = 20'(len);
    pat_num  = 8'(pat);
    cap_num  = 3'(cap);
    mon_clr  = 1'b1;
    tick();
    mon_clr  = 1'b0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      tick();
      start = (mid_start && k == 20);
      if (scan_done) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!got) check("done_timeout", 0, 1);
    tick();
    tick();
  endtask

  typedef struct {
    int len;
    int pat;
    int cap;
    int e_shift;
    int e_cap;
    int e_pat;
    int e_busy;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit got;
    int k;

    vecs[0] = '{3, 1, 2,  6, 2, 1,  68};
    vecs[1] = '{3, 3, 1, 12, 3, 3, 134};
    vecs[2] = '{2, 1, 0,  4, 1, 1,  50};
    vecs[3] = '{2, 1, 7,  4, 4, 1,  56};
    vecs[4] = '{0, 2, 2,  0, 4, 2,  32};
    vecs[5] = '{5, 0, 3,  0, 0, 0,   8};
    vecs[6] = '{1, 2, 4,  3, 8, 2,  64};

    rst = 1'b1; start = 1'b0; lock = 1'b1;
    scan_len = '0; pat_num = '0; cap_num = '0;
    tick();
    tick();
    check("rst_outputs", {tck, test_se, sub_rst, busy, scan_done, abort}, 0);
    check("rst_pat_cnt", pat_cnt, 0);
    rst = 1'b0;
    tick(); tick(); tick();

    for (int i = 0; i < 7; i++) begin
      do_run(vecs[i].len, vecs[i].pat, vecs[i].cap, 1'b0);
      check($sformatf("v%0d_shift_edges", i), n_shift, vecs[i].e_shift);
      check($sformatf("v%0d_cap_edges", i), n_cap, vecs[i].e_cap);
      check($sformatf("v%0d_pat_cnt", i), pat_cnt, vecs[i].e_pat);
      check($sformatf("v%0d_busy_cycles", i), n_busy, vecs[i].e_busy);
      check($sformatf("v%0d_subrst_cycles", i), n_sub, 8);
      check($sformatf("v%0d_done_rises", i), n_done_rise, 1);
      check($sformatf("v%0d_pulse_width", i), n_bad_run, 0);
      check($sformatf("v%0d_se_hazard", i), n_haz, 0);
      check($sformatf("v%0d_done_abort", i), {scan_done, abort}, 2);
      check($sformatf("v%0d_idle", i), {busy, tck, test_se}, 0);
    end

    // start while busy must not restart the run
    do_run(3, 1, 2, 1'b1);
    check("busy_start_cycles", n_busy, 68);
    check("busy_start_done_rises", n_done_rise, 1);
    check("busy_start_pat_cnt", pat_cnt, 1);

    // start with lock low in IDLE is ignored
    lock = 1'b0;
    tick(); tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("nolock_start_busy", busy, 0);
    check("nolock_start_done_kept", scan_done, 1);
    lock = 1'b1;
    tick(); tick(); tick();

    // lock loss during the second LOAD
    scan_len = 20'd3; pat_num = 8'd3; cap_num = 3'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    got = 1'b0;
    for (int j = 0; j < 500; j++) begin
      tick();
      if (pat_cnt == 8'd1 && test_se && tck) begin
        got = 1'b1;
        break;
      end
    end
    check("second_load_reached", got, 1);
    lock = 1'b0;
    k = 0;
    got = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      tick();
      if (abort) begin
        k = j;
        got = 1'b1;
        break;
      end
    end
    check("abort_seen", got, 1);
    check("abort_latency_ok", (k >= 1 && k <= 3), 1);
    check("abort_outputs", {tck, test_se, sub_rst, busy}, 0);
    check("abort_pat_cnt", pat_cnt, 1);
    check("abort_no_done", scan_done, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("abort_start_ignored", {busy, abort}, 1);
    lock = 1'b1;
    tick(); tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_clears_abort", {busy, abort}, 2);
    got = 1'b0;
    for (int j = 0; j < 3000; j++) begin
      tick();
      if (scan_done) begin
        got = 1'b1;
        break;
      end
    end
    check("restart_done", got, 1);
    check("restart_pat_cnt", pat_cnt, 3);

    // asynchronous reset during the second capture burst
    tick(); tick();
    scan_len = 20'd2; pat_num = 8'd2; cap_num = 3'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    got = 1'b0;
    for (int j = 0; j < 500; j++) begin
      tick();
      if (busy && !test_se && tck && pat_cnt == 8'd1) begin
        got = 1'b1;
        break;
      end
    end
    check("cap_reached", got, 1);
    rst = 1'b1;
    #1;
    check("midrun_rst_outputs", {tck, test_se, sub_rst, busy, scan_done, abort}, 0);
    check("midrun_rst_pat_cnt", pat_cnt, 0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    check("post_rst_idle", {busy, tck}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
